// File: rtl/decim_out_buf.sv
// Decimating output buffer: keeps one sample per RATE input strobes and queues it in a FWFT FIFO.
// Define DECIM_AVG_EN to emit the boxcar average of each group instead of its last sample.
module decim_out_buf #(
  parameter int DW    = 12,
  parameter int RATE  = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [DW-1:0]       in,
  input  logic                       sync,
  output logic signed [DW-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int LR = $clog2(RATE);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LR-1:0] CNT_LAST = LR'(RATE - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [LR-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic          produce;
  logic [DW-1:0] sample;
  logic          pop;
  logic          full;
  logic          do_push;
  logic          drop;

`ifdef DECIM_AVG_EN
  localparam int ACCW = DW + LR;

  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] in_ext;
  logic signed [ACCW-1:0] sum;

  // The group sum needs LR guard bits; the shifted result always fits back into DW.
  assign in_ext = {{LR{in[DW-1]}}, in};
  assign sum    = acc_q + in_ext;
  assign sample = sum[LR +: DW];
`else
  assign sample = in;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    produce = 1'b0;
`ifdef DECIM_AVG_EN
    acc_d   = acc_q;
`endif
    if (sync) begin
      cnt_d = en ? LR'(1) : '0;
`ifdef DECIM_AVG_EN
      acc_d = en ? in_ext : '0;
`endif
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        produce = 1'b1;
        cnt_d   = '0;
`ifdef DECIM_AVG_EN
        acc_d   = '0;
`endif
      end else begin
        cnt_d = cnt_q + LR'(1);
`ifdef DECIM_AVG_EN
        acc_d = sum;
`endif
      end
    end
  end

  assign pop     = (level_q != '0) && out_ready;
  assign full    = (level_q == LVL_FULL);
  // A full FIFO can still accept a push when the head leaves on the same edge.
  assign do_push = produce && (!full || pop);
  assign drop    = produce && full && !pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + LW'(do_push) - LW'(pop);
    overflow_d = overflow_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = sample;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef DECIM_AVG_EN
      acc_q      <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
`ifdef DECIM_AVG_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_decim_out_buf.sv
// Randomized and directed bench for decim_out_buf against a queue-based reference model.
// Works in both pick mode and DECIM_AVG_EN averaging mode.
module tb_decim_out_buf;

  localparam int DW    = 12;
  localparam int RATE  = 4;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

`ifdef DECIM_AVG_EN
  localparam int EXP_A  = 101;
  localparam int EXP_BP = 1;
  localparam int EXP_S  = 8;
`else
  localparam int EXP_A  = 103;
  localparam int EXP_BP = 3;
  localparam int EXP_S  = 10;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic signed [DW-1:0] in_s;
  logic                 sync;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [LW-1:0]        level;
  logic                 overflow;
  logic                 clr_ovf;

  int checks = 0;
  int errors = 0;

  int grp[$];
  int fifo_m[$];
  bit ovf_m  = 1'b0;
  bit fresh  = 1'b0;
  bit known  = 1'b0;

  always #5 clk = ~clk;

  decim_out_buf #(.DW(DW), .RATE(RATE), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .in(in_s),
    .sync(sync),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level(level),
    .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Group result from the raw inputs: floor of the mean, or simply the last sample.
  function automatic int groupValue();
`ifdef DECIM_AVG_EN
    int s = 0;
    foreach (grp[i]) s += grp[i];
    return s >>> $clog2(RATE);
`else
    return grp[RATE-1];
`endif
  endfunction

  task automatic modelStep();
    bit pop;
    bit produce;
    bit drop;
    int v;
    pop = 1'b0; produce = 1'b0; drop = 1'b0; v = 0;
    if (!rst_n) begin
      grp.delete();
      fifo_m.delete();
      ovf_m = 1'b0;
      fresh = 1'b1;
      known = 1'b1;
    end else begin
      pop = (fifo_m.size() > 0) && out_ready;
      if (sync) begin
        grp.delete();
        if (en) grp.push_back(int'(in_s));
      end else if (en) begin
        grp.push_back(int'(in_s));
        if (grp.size() == RATE) begin
          produce = 1'b1;
          v = groupValue();
          grp.delete();
        end
      end
      drop = produce && (fifo_m.size() == DEPTH) && !pop;
      if (pop) void'(fifo_m.pop_front());
      if (produce && !drop) begin
        fifo_m.push_back(v);
        fresh = 1'b0;
      end
      if (drop) ovf_m = 1'b1;
      else if (clr_ovf) ovf_m = 1'b0;
    end
  endtask

  task automatic compareAll();
    if (!known) return;
    checkOutput("out_valid", int'(out_valid), int'(fifo_m.size() > 0));
    checkOutput("level", int'(level), fifo_m.size());
    checkOutput("overflow", int'(overflow), int'(ovf_m));
    if (fifo_m.size() > 0) checkOutput("out_data", int'(out_data), fifo_m[0]);
    else if (fresh) checkOutput("out_data_after_reset", int'(out_data), 0);
  endtask

  // Inputs change only at the falling edge; model and checks follow each rising edge.
  task automatic applyStimulus(input logic e, input logic signed [DW-1:0] d, input logic s,
                               input logic r, input logic c, input logic rn);
    en = e; in_s = d; sync = s; out_ready = r; clr_ovf = c; rst_n = rn;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; in_s = '0;
    repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_level", int'(level), 0);

    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("pick_level_le1", int'(level <= 1), 1);
    end

    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(100 + i), 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("grp_100_valid", int'(out_valid), 1);
    checkOutput("grp_100_data", int'(out_data), EXP_A);
    applyStimulus(1'b1, -12'sd1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, -12'sd1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, -12'sd1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, -12'sd2, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("grp_neg_data", int'(out_data), -2);

    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    for (int k = 0; k < 9; k++)
      for (int j = 0; j < RATE; j++)
        applyStimulus(1'b1, DW'(16 * k + j), 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_level_full", int'(level), DEPTH);
    checkOutput("bp_overflow_set", int'(overflow), 1);
    checkOutput("bp_head_first", int'(out_data), EXP_BP);
    drain();
    checkOutput("bp_drained_level", int'(level), 0);
    checkOutput("bp_overflow_sticky", int'(overflow), 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("bp_overflow_cleared", int'(overflow), 0);

    for (int k = 0; k < DEPTH * RATE; k++)
      applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < RATE - 1; j++)
      applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("full_pushpop_level", int'(level), DEPTH);
    checkOutput("full_pushpop_ovf", int'(overflow), 0);
    drain();

    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 12'sd40, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 12'sd41, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 12'sd7, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 12'sd8, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 12'sd9, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("sync_no_partial", int'(out_valid), 0);
    applyStimulus(1'b1, 12'sd10, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("sync_valid", int'(out_valid), 1);
    checkOutput("sync_data", int'(out_data), EXP_S);
    drain();

    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5 * RATE + 2; k++)
      applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_reset_level", int'(level), 5);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_reset_valid", int'(out_valid), 0);
    checkOutput("mid_reset_level", int'(level), 0);
    checkOutput("mid_reset_data", int'(out_data), 0);
    checkOutput("mid_reset_ovf", int'(overflow), 0);
    for (int j = 0; j < RATE - 1; j++)
      applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("post_reset_partial", int'(out_valid), 0);
    applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("post_reset_first", int'(out_valid), 1);

    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = (i < 1500) ? (($urandom % 5) == 0) : (($urandom % 3) != 0);
      applyStimulus(($urandom % 4) != 0, DW'($urandom), ($urandom % 50) == 0, r,
                    ($urandom % 20) == 0, ($urandom % 400) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
